// File: rtl/instr_mem_responder_pkg.sv
// rtl/instr_mem_responder_pkg.sv - shared constants and FSM state type for the instruction-memory responder
package instr_mem_responder_pkg;

    // Instruction returned whenever no real word is available (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        IMEM_IDLE = 1'b0,
        IMEM_WAIT = 1'b1
    } imem_state_e;

endpackage

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - fetch/backdoor-load bundle between PC stage and instruction memory
interface instr_mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_fetch;
    logic            load_en;
    logic [XLEN-1:0] load_addr;
    logic [31:0]     load_data;
    logic [31:0]     instr_fetch;
    logic            instr_valid;
    logic            stall_fetch;
    logic            misaligned;

    modport master (
        output pc_fetch, load_en, load_addr, load_data,
        input  instr_fetch, instr_valid, stall_fetch, misaligned
    );

    modport slave (
        input  pc_fetch, load_en, load_addr, load_data,
        output instr_fetch, instr_valid, stall_fetch, misaligned
    );
endinterface

// File: rtl/instr_mem_responder_line_buffer.sv
// rtl/instr_mem_responder_line_buffer.sv - one-entry tagged line buffer with fill, invalidate and hit compare
module instr_line_buffer #(
    parameter int TAG_W = 30,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      hit_data
);
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;

    // Next buffer contents: a fill always wins over an invalidate of the same edge
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end else if (inv_en && (inv_idx == tag_q[IDX_W-1:0])) begin
            valid_d = 1'b0;
        end
    end

    // Only the valid bit needs a reset; tag/data are meaningless while invalid
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data registers
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_data = data_q;
endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fetch-stage instruction memory with multi-cycle backing read and line buffer
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_mem_responder_if.slave  bus
);
    localparam int IDX   = $clog2(MEM_WORDS);
    localparam int TAG_W = XLEN - 2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // cnt holds the WAIT cycles still to go, counting the current one
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [31:0]      mem_q [MEM_WORDS];
    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;

    logic [TAG_W-1:0] pc_tag;
    logic [IDX-1:0]   load_idx;
    logic             pc_mis;
    logic             buf_hit;
    logic [31:0]      buf_data;
    logic             fill_en;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX-1:0]   fill_idx;
    logic [31:0]      fill_data;
    logic             unused_load_bits;

    assign pc_tag   = bus.pc_fetch[XLEN-1:2];
    assign pc_mis   = |bus.pc_fetch[1:0];
    assign load_idx = bus.load_addr[IDX+1:2];
    assign fill_idx = fill_tag[IDX-1:0];
    assign unused_load_bits = ^{bus.load_addr[XLEN-1:IDX+2], bus.load_addr[1:0]};

    // A backdoor write landing on the fill index in the same edge must be seen by the fill
    assign fill_data = (bus.load_en && (load_idx == fill_idx)) ? bus.load_data : mem_q[fill_idx];

    // Miss/fill sequencing: start, restart on PC change, abort on misaligned, fill on last wait cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_tag_d = miss_tag_q;
        fill_en    = 1'b0;
        fill_tag   = miss_tag_q;
        case (state_q)
            IMEM_IDLE: begin
                if (!pc_mis && !buf_hit) begin
                    if (LATENCY == 1) begin
                        fill_en  = 1'b1;
                        fill_tag = pc_tag;
                    end else begin
                        state_d    = IMEM_WAIT;
                        miss_tag_d = pc_tag;
                        cnt_d      = CNT_LOAD;
                    end
                end
            end
            IMEM_WAIT: begin
                if (pc_mis) begin
                    state_d = IMEM_IDLE;
                end else if (pc_tag != miss_tag_q) begin
                    miss_tag_d = pc_tag;
                    cnt_d      = CNT_LOAD;
                end else if (cnt_q != CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    fill_en = 1'b1;
                    state_d = IMEM_IDLE;
                end
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    // FSM and counter registers, cleared by reset so a pending read is dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending miss tag; only meaningful while waiting
    always_ff @(posedge clk) begin
        miss_tag_q <= miss_tag_d;
    end

    // Backing array, written only through the backdoor port and never reset
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem_q[load_idx] <= bus.load_data;
        end
    end

    instr_line_buffer #(
        .TAG_W (TAG_W),
        .IDX_W (IDX)
    ) u_line_buffer (
        .clk        (clk),
        .reset      (reset),
        .fill_en    (fill_en),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .inv_en     (bus.load_en),
        .inv_idx    (load_idx),
        .lookup_tag (pc_tag),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );

    // Fetch outputs: reset forces quiet values, misaligned beats wait/hit/miss
    always_comb begin
        bus.instr_fetch = NOP_INSTR;
        bus.instr_valid = 1'b0;
        bus.stall_fetch = 1'b0;
        bus.misaligned  = 1'b0;
        if (reset) begin
            if (pc_mis) begin
                bus.misaligned  = 1'b1;
                bus.instr_valid = 1'b1;
            end else if (state_q == IMEM_WAIT) begin
                bus.stall_fetch = 1'b1;
            end else if (buf_hit) begin
                bus.instr_fetch = buf_data;
                bus.instr_valid = 1'b1;
            end else begin
                bus.stall_fetch = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed vector table plus randomized model check for instr_mem_responder
module tb_instr_mem_responder;
    localparam int LAT   = 2;
    localparam int WORDS = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          r;
        logic [31:0] pc;
        bit          le;
        logic [31:0] la;
        logic [31:0] ld;
        bit          ev;
        bit          es;
        bit          em;
        logic [31:0] ei;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tbl[$];

    // Reference state: the memory image, the buffered line, and an outstanding read
    logic [31:0] m_mem [WORDS];
    bit          m_bvalid;
    logic [29:0] m_btag;
    logic [31:0] m_bdata;
    bit          m_pend;
    logic [29:0] m_ptag;
    int          m_left;

    instr_mem_responder_if #(.XLEN(32)) bus ();

    instr_mem_responder #(
        .XLEN      (32),
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] model_out(input bit r, input logic [31:0] pc);
        if (!r) return {3'b000, NOP};
        if (pc[1:0] != 2'b00) return {3'b101, NOP};
        if (m_pend) return {3'b010, NOP};
        if (m_bvalid && m_btag == pc[31:2]) return {3'b100, m_bdata};
        return {3'b010, NOP};
    endfunction

    task automatic model_edge(input bit r, input logic [31:0] pc, input bit le,
                              input logic [31:0] la, input logic [31:0] ld);
        logic [29:0] t;
        bit          do_fill;
        logic [29:0] ftag;
        t       = pc[31:2];
        do_fill = 0;
        ftag    = '0;
        if (!r) begin
            m_pend   = 0;
            m_bvalid = 0;
        end else if (pc[1:0] != 2'b00) begin
            m_pend = 0;
        end else begin
            if (!m_pend && !(m_bvalid && m_btag == t)) begin
                m_pend = 1;
                m_ptag = t;
                m_left = LAT;
            end else if (m_pend && m_ptag != t) begin
                m_ptag = t;
                m_left = LAT;
            end
            if (m_pend) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    do_fill = 1;
                    ftag    = m_ptag;
                    m_pend  = 0;
                end
            end
        end
        if (le) begin
            m_mem[la[11:2]] = ld;
            if (m_btag[9:0] == la[11:2]) m_bvalid = 0;
        end
        if (do_fill) begin
            m_btag   = ftag;
            m_bdata  = m_mem[ftag[9:0]];
            m_bvalid = 1;
        end
    endtask

    task automatic step(input bit r, input logic [31:0] pc, input bit le, input logic [31:0] la,
                        input logic [31:0] ld, input bit chk, input bit use_exp,
                        input logic [34:0] exp_in, input string name);
        logic [34:0] exp_v;
        logic [34:0] got;
        reset         = r;
        bus.pc_fetch  = pc;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        @(negedge clk);
        if (chk) begin
            exp_v = use_exp ? exp_in : model_out(r, pc);
            got   = {bus.instr_valid, bus.stall_fetch, bus.misaligned, bus.instr_fetch};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s pc=%h: got valid=%b stall=%b mis=%b instr=%h, expected valid=%b stall=%b mis=%b instr=%h",
                         name, pc, got[34], got[33], got[32], got[31:0],
                         exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
            end
        end
        model_edge(r, pc, le, la, ld);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input logic [31:0] pc, input bit le, input logic [31:0] la,
                       input logic [31:0] ld, input bit ev, input bit es, input bit em,
                       input logic [31:0] ei);
        vec_t v;
        v.r = r; v.pc = pc; v.le = le; v.la = la; v.ld = ld;
        v.ev = ev; v.es = es; v.em = em; v.ei = ei;
        tbl.push_back(v);
    endtask

    task automatic add_stall(input logic [31:0] pc);
        add(1, pc, 0, 0, 0, 0, 1, 0, NOP);
    endtask

    task automatic add_hit(input logic [31:0] pc, input logic [31:0] d);
        add(1, pc, 0, 0, 0, 1, 0, 0, d);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0050_0093 : (32'hC0DE_0000 | i);
    endfunction

    initial begin
        logic [31:0] pcs [10];
        logic [31:0] pc;
        logic [31:0] la;
        bit          r;
        bit          le;
        checks   = 0;
        errors   = 0;
        m_bvalid = 0;
        m_btag   = '0;
        m_bdata  = '0;
        m_pend   = 0;
        m_ptag   = '0;
        m_left   = 0;
        reset         = 1'b0;
        bus.pc_fetch  = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < WORDS; i++) begin
            step(0, 0, 1, i * 4, init_word(i), 0, 0, '0, "preload");
        end

        add(0, 32'h0, 0, 0, 0, 0, 0, 0, NOP);
        add_stall(32'h0); add_stall(32'h0); add_hit(32'h0, 32'h0050_0093);
        add_stall(32'h4); add_stall(32'h4); add_hit(32'h4, 32'hC0DE_0001); add_hit(32'h4, 32'hC0DE_0001);
        add_stall(32'h8); add_stall(32'h8); add_hit(32'h8, 32'hC0DE_0002);
        add_stall(32'h4); add_stall(32'h4); add_hit(32'h4, 32'hC0DE_0001);
        add(1, 32'h6, 0, 0, 0, 1, 0, 1, NOP);
        add_stall(32'h8);
        add(1, 32'h6, 0, 0, 0, 1, 0, 1, NOP);
        add_stall(32'h8); add_stall(32'h8); add_hit(32'h8, 32'hC0DE_0002);
        add_stall(32'h10); add_stall(32'h20); add_stall(32'h20); add_hit(32'h20, 32'hC0DE_0008);
        add_stall(32'h10); add_stall(32'h10); add_hit(32'h10, 32'hC0DE_0004);
        add(1, 32'h10, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 0, 32'hC0DE_0004);
        add_stall(32'h10); add_stall(32'h10); add_hit(32'h10, 32'hDEAD_BEEF);
        add_stall(32'h1010); add_stall(32'h1010); add_hit(32'h1010, 32'hDEAD_BEEF);
        add_stall(32'h20);
        add(0, 32'h20, 0, 0, 0, 0, 0, 0, NOP);
        add_stall(32'h20); add_stall(32'h20); add_hit(32'h20, 32'hC0DE_0008);
        add_stall(32'h30);
        add(1, 32'h30, 1, 32'h30, 32'h1234_5678, 0, 1, 0, NOP);
        add_hit(32'h30, 32'h1234_5678);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].pc, tbl[i].le, tbl[i].la, tbl[i].ld, 1, 1,
                 {tbl[i].ev, tbl[i].es, tbl[i].em, tbl[i].ei}, $sformatf("table[%0d]", i));
        end

        pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20, 32'h1010, 32'h6, 32'h2, 32'h1004};
        pc  = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 40) begin
                if ($urandom_range(3) == 0) pc = {26'd0, 4'($urandom_range(15)), 2'b00};
                else pc = pcs[$urandom_range(9)];
            end
            r  = ($urandom_range(99) != 0);
            le = ($urandom_range(9) == 0);
            la = {$urandom_range(3) == 0 ? 20'h00001 : 20'h00000, 6'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
            step(r, pc, le, la, $urandom, 1, 0, '0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
